// File: rtl/baterias_pkg.sv
// Shared types and defaults for the two-battery supply sequencer.
// Charge levels are 4-bit codes from the charge-sensing front end.
package baterias_pkg;

    localparam int ANCHO_CARGA        = 4;
    localparam int UMBRAL_BAJO_DEF    = 2;
    localparam int CICLOS_FILTRO_DEF  = 4;
    localparam int CICLOS_MUERTOS_DEF = 2;

    localparam logic [1:0] BATERIA_NINGUNA = 2'd0;
    localparam logic [1:0] BATERIA_1       = 2'd1;
    localparam logic [1:0] BATERIA_2       = 2'd2;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        CON_B1     = 3'd1,
        CON_B2     = 3'd2,
        CONMUTANDO = 3'd3,
        SIN_CARGA  = 3'd4
    } estado_t;

    // A battery is usable only strictly above the low threshold.
    function automatic logic carga_ok(input logic [ANCHO_CARGA-1:0] carga, input int umbral);
        return int'(carga) > umbral;
    endfunction

endpackage

// File: rtl/filtro_persistencia.sv
// Saturating counter of consecutive true samples. The expired flag rises on the
// sample that completes the run, so the caller can act on that very edge.
module filtro_persistencia #(
    parameter int CICLOS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic limpiar,
    input  logic muestra,
    output logic expirado
);

    localparam logic [3:0] CUENTA_MAX    = 4'(CICLOS);
    localparam logic [3:0] CUENTA_EXPIRA = 4'(CICLOS - 1);

    logic [3:0] cuenta_reg;
    logic [3:0] cuenta_next;

    always_comb begin
        cuenta_next = cuenta_reg;
        if (limpiar || !muestra) begin
            cuenta_next = '0;
        end else if (cuenta_reg < CUENTA_MAX) begin
            cuenta_next = cuenta_reg + 4'd1;
        end
    end

    // Must not depend on limpiar: the owner derives limpiar from this flag.
    assign expirado = muestra && (cuenta_reg >= CUENTA_EXPIRA);

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_reg <= '0;
        end else begin
            cuenta_reg <= cuenta_next;
        end
    end

endmodule

// File: rtl/controlador_conmutacion_baterias.sv
// Selects which of two batteries feeds the load, with filtered low detection,
// break-before-make dead time, manual switch requests and a depletion alarm.
module controlador_conmutacion_baterias
    import baterias_pkg::*;
#(
    parameter int UMBRAL_BAJO    = UMBRAL_BAJO_DEF,
    parameter int CICLOS_FILTRO  = CICLOS_FILTRO_DEF,
    parameter int CICLOS_MUERTOS = CICLOS_MUERTOS_DEF,
    parameter int ANCHO_CONTADOR = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                carga_bateria1,
    input  logic [3:0]                carga_bateria2,
    input  logic                      solicitud_cambio,
    output logic                      habilitar_b1,
    output logic                      habilitar_b2,
    output logic                      advertencia_bateria_1,
    output logic                      advertencia_bateria_2,
    output logic                      alarma_total,
    output logic [ANCHO_CONTADOR-1:0] contador_conmutaciones
);

    localparam logic [3:0] ULTIMO_MUERTO = 4'(CICLOS_MUERTOS - 1);

    estado_t                   estado_reg, estado_next;
    logic [1:0]                destino_reg, destino_next;
    logic [3:0]                muertos_reg, muertos_next;
    logic [ANCHO_CONTADOR-1:0] contador_reg, contador_next;
    logic                      hab_b1_reg, hab_b2_reg, alarma_reg;

    logic [ANCHO_CARGA-1:0] cargas [2];
    logic [1:0]             bateria_ok;
    logic                   activa_cero;
    logic                   otra_ok;
    logic                   muestra_filtro;
    logic                   limpiar_filtro;
    logic                   filtro_expirado;
    logic                   entra_conmutacion;

    assign cargas[0] = carga_bateria1;
    assign cargas[1] = carga_bateria2;

    // Per-battery qualification and zero-charge warnings, independent of state.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bateria
            logic advertencia_reg;

            assign bateria_ok[gi] = carga_ok(cargas[gi], UMBRAL_BAJO);

            always_ff @(posedge clk) begin
                if (rst) begin
                    advertencia_reg <= 1'b0;
                end else begin
                    advertencia_reg <= (cargas[gi] == '0);
                end
            end
        end
    endgenerate

    assign advertencia_bateria_1 = g_bateria[0].advertencia_reg;
    assign advertencia_bateria_2 = g_bateria[1].advertencia_reg;

    // The single filter watches the active battery while connected and
    // watches for any usable battery while the load is unpowered.
    always_comb begin
        activa_cero    = 1'b0;
        otra_ok        = 1'b0;
        muestra_filtro = 1'b0;
        case (estado_reg)
            CON_B1: begin
                activa_cero    = (carga_bateria1 == '0);
                otra_ok        = bateria_ok[1];
                muestra_filtro = !bateria_ok[0];
            end
            CON_B2: begin
                activa_cero    = (carga_bateria2 == '0);
                otra_ok        = bateria_ok[0];
                muestra_filtro = !bateria_ok[1];
            end
            SIN_CARGA: begin
                muestra_filtro = bateria_ok[0] || bateria_ok[1];
            end
            default: ;
        endcase
    end

    filtro_persistencia #(
        .CICLOS (CICLOS_FILTRO)
    ) u_filtro (
        .clk      (clk),
        .rst      (rst),
        .limpiar  (limpiar_filtro),
        .muestra  (muestra_filtro),
        .expirado (filtro_expirado)
    );

    always_comb begin
        estado_next  = estado_reg;
        destino_next = destino_reg;
        muertos_next = muertos_reg;
        case (estado_reg)
            ESPERA: begin
                if (bateria_ok[0]) begin
                    estado_next = CON_B1;
                end else if (bateria_ok[1]) begin
                    estado_next = CON_B2;
                end else begin
                    estado_next = SIN_CARGA;
                end
            end
            CON_B1, CON_B2: begin
                // Expiry and request share one branch so a coincidence is one switch.
                if ((filtro_expirado || solicitud_cambio) && otra_ok) begin
                    estado_next  = CONMUTANDO;
                    destino_next = (estado_reg == CON_B1) ? BATERIA_2 : BATERIA_1;
                    muertos_next = '0;
                end else if (filtro_expirado && activa_cero) begin
                    estado_next = SIN_CARGA;
                end
            end
            CONMUTANDO: begin
                if (muertos_reg >= ULTIMO_MUERTO) begin
                    estado_next  = (destino_reg == BATERIA_1) ? CON_B1 : CON_B2;
                    muertos_next = '0;
                end else begin
                    muertos_next = muertos_reg + 4'd1;
                end
            end
            SIN_CARGA: begin
                if (filtro_expirado) begin
                    estado_next = bateria_ok[0] ? CON_B1 : CON_B2;
                end
            end
            default: begin
                estado_next = ESPERA;
            end
        endcase
    end

    // Every state entry starts the filter from zero.
    assign limpiar_filtro    = (estado_next != estado_reg);
    assign entra_conmutacion = (estado_next == CONMUTANDO) && (estado_reg != CONMUTANDO);

    always_comb begin
        contador_next = contador_reg;
        if (entra_conmutacion && (contador_reg != '1)) begin
            contador_next = contador_reg + ANCHO_CONTADOR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg   <= ESPERA;
            destino_reg  <= BATERIA_NINGUNA;
            muertos_reg  <= '0;
            contador_reg <= '0;
            hab_b1_reg   <= 1'b0;
            hab_b2_reg   <= 1'b0;
            alarma_reg   <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            destino_reg  <= destino_next;
            muertos_reg  <= muertos_next;
            contador_reg <= contador_next;
            hab_b1_reg   <= (estado_next == CON_B1);
            hab_b2_reg   <= (estado_next == CON_B2);
            alarma_reg   <= (estado_next == SIN_CARGA);
        end
    end

    assign habilitar_b1           = hab_b1_reg;
    assign habilitar_b2           = hab_b2_reg;
    assign alarma_total           = alarma_reg;
    assign contador_conmutaciones = contador_reg;

endmodule
